// File: rtl/seg7_scan_driver_if.sv
// Display-side signal bundle for seg7_scan_driver: divided-clock strobe, value/enable inputs, and
// the active-low anode/cathode drive outputs.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  div_clk;
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_req;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output div_clk, en, value, dp_req,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  div_clk, en, value, dp_req,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Common-anode seven-segment scan driver: one digit per div_clk period, frame-level shadow of value.
// Optional leading-zero blanking is compiled in with SEG7_LEADING_ZERO_BLANK_EN.
//
// state  | meaning
// BLANK  | display off, waiting for a tick with en=1
// SCAN   | driving digit idx from the shadow register
module seg7_scan_driver #(
    parameter int DIGITS = 4
) (
    input logic               clock,
    input logic               reset,
    seg7_scan_driver_if.slave dsp_if
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic                w_tick;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] w_shadow_nxt;
    logic                w_load;

    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame_done;
    logic [DIGITS-1:0]   w_an_nxt;
    logic [6:0]          w_seg_nxt;
    logic                w_dp_nxt;
    logic                w_frame_done_nxt;

    logic [3:0]          w_nibble;
    logic                w_digit_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // div_clk is only ever sampled; s2 & ~s3 gives one tick per sampled rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= dsp_if.div_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_tick = r_sync2 & ~r_sync3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_BLANK;
            r_idx    <= '0;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    // en low overrides everything, including a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        if (!dsp_if.en) begin
            w_state_nxt = ST_BLANK;
            w_idx_nxt   = '0;
        end else if (w_tick) begin
            case (r_state)
                ST_BLANK: begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
                default: begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt = '0;
                        w_load    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            endcase
        end
        w_shadow_nxt = w_load ? dsp_if.value : r_shadow;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] r_msd;
    logic [IDX_W-1:0] w_msd_nxt;

    function automatic logic [IDX_W-1:0] msd_of(input logic [4*DIGITS-1:0] v);
        logic [IDX_W-1:0] m;
        m = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'h0) m = IDX_W'(i);
        end
        return m;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_msd <= '0;
        else        r_msd <= w_msd_nxt;
    end

    assign w_msd_nxt     = w_load ? msd_of(dsp_if.value) : r_msd;
    assign w_digit_blank = (w_idx_nxt > w_msd_nxt);
`else
    assign w_digit_blank = 1'b0;
`endif

    assign w_nibble = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];

    // Outputs are computed from next-state values so they change on the same edge as state/idx.
    always_comb begin
        w_an_nxt         = '1;
        w_seg_nxt        = 7'h7F;
        w_dp_nxt         = 1'b1;
        w_frame_done_nxt = w_load;
        if (w_state_nxt == ST_SCAN) begin
            w_an_nxt  = ~(DIGITS'(1) << w_idx_nxt);
            w_seg_nxt = w_digit_blank ? 7'h7F : hex_to_seg(w_nibble);
            w_dp_nxt  = w_tick ? ~dsp_if.dp_req[w_idx_nxt] : r_dp;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign dsp_if.an         = r_an;
    assign dsp_if.seg        = r_seg;
    assign dsp_if.dp         = r_dp;
    assign dsp_if.frame_done = r_frame_done;
endmodule
